// File: rtl/approx_adder_eval_ctrl.sv
// Evaluation sequencer for an external approximate adder: issues operand pairs, computes
// the exact sum and accumulates sample count, max AE, SAE, SSE and error count per run.
module approx_adder_eval_ctrl #(
  parameter int W     = 32,
  parameter int N_W   = 16,
  parameter int ACC_W = 2*W+2+N_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  input  logic [W:0]       dut_sum,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   n_done,
  output logic [W:0]       max_ae,
  output logic [ACC_W-1:0] sae,
  output logic [ACC_W-1:0] sse,
  output logic [N_W-1:0]   err_cnt,
  output logic             ovf
);

  localparam int SQ_W  = 2*W+2;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   target_q, target_d;
  logic [N_W-1:0]   issued_q, issued_d;
  logic             in_ready_q, in_ready_d;
  logic [W-1:0]     dut_a_q, dut_a_d;
  logic [W-1:0]     dut_b_q, dut_b_d;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [W:0]       ae_q, ae_d;
  logic [N_W-1:0]   n_done_q, n_done_d;
  logic [W:0]       max_ae_q, max_ae_d;
  logic [ACC_W-1:0] sae_q, sae_d;
  logic [ACC_W-1:0] sse_q, sse_d;
  logic [N_W-1:0]   err_cnt_q, err_cnt_d;
  logic             ovf_q, ovf_d;

  logic [W:0]       exact;
  logic [SQ_W-1:0]  ae_sq;
  logic [SUM_W-1:0] sae_sum;
  logic [SUM_W-1:0] sse_sum;
  logic             accept;

  // Sums are formed one bit wider than the widest operand so any carry past ACC_W is visible.
  always_comb begin
    exact   = {1'b0, dut_a_q} + {1'b0, dut_b_q};
    ae_sq   = SQ_W'(ae_q) * SQ_W'(ae_q);
    sae_sum = SUM_W'(sae_q) + SUM_W'(ae_q);
    sse_sum = SUM_W'(sse_q) + SUM_W'(ae_sq);
    accept  = in_valid && in_ready_q;
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    issued_d   = issued_q;
    dut_a_d    = dut_a_q;
    dut_b_d    = dut_b_q;
    ae_d       = ae_q;
    n_done_d   = n_done_q;
    max_ae_d   = max_ae_q;
    sae_d      = sae_q;
    sse_d      = sse_q;
    err_cnt_d  = err_cnt_q;
    ovf_d      = ovf_q;
    s1_v_d     = accept;
    s2_v_d     = s1_v_q;
    in_ready_d = 1'b0;

    if (accept) begin
      dut_a_d = in_a;
      dut_b_d = in_b;
    end

    if (s1_v_q) begin
      ae_d = (dut_sum >= exact) ? (dut_sum - exact) : (exact - dut_sum);
    end

    if (s2_v_q) begin
      n_done_d  = n_done_q + N_W'(1);
      err_cnt_d = err_cnt_q + N_W'(ae_q != '0);
      if (ae_q > max_ae_q) begin
        max_ae_d = ae_q;
      end
      if (|sae_sum[SUM_W-1:ACC_W]) begin
        sae_d = '1;
        ovf_d = 1'b1;
      end else begin
        sae_d = sae_sum[ACC_W-1:0];
      end
      if (|sse_sum[SUM_W-1:ACC_W]) begin
        sse_d = '1;
        ovf_d = 1'b1;
      end else begin
        sse_d = sse_sum[ACC_W-1:0];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d  = num_samples;
          issued_d  = '0;
          n_done_d  = '0;
          max_ae_d  = '0;
          sae_d     = '0;
          sse_d     = '0;
          err_cnt_d = '0;
          ovf_d     = 1'b0;
          state_d   = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          issued_d = issued_q + N_W'(1);
          if (issued_d == target_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!s1_v_q && !s2_v_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RUN) && (issued_d < target_d);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      in_ready_q <= 1'b0;
      dut_a_q    <= '0;
      dut_b_q    <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      ae_q       <= '0;
      n_done_q   <= '0;
      max_ae_q   <= '0;
      sae_q      <= '0;
      sse_q      <= '0;
      err_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      in_ready_q <= in_ready_d;
      dut_a_q    <= dut_a_d;
      dut_b_q    <= dut_b_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      ae_q       <= ae_d;
      n_done_q   <= n_done_d;
      max_ae_q   <= max_ae_d;
      sae_q      <= sae_d;
      sse_q      <= sse_d;
      err_cnt_q  <= err_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready = in_ready_q;
  assign dut_a    = dut_a_q;
  assign dut_b    = dut_b_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign n_done   = n_done_q;
  assign max_ae   = max_ae_q;
  assign sae      = sae_q;
  assign sse      = sse_q;
  assign err_cnt  = err_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_approx_adder_eval_ctrl.sv
// Bench for approx_adder_eval_ctrl: a transaction-level model (accepted samples retire two
// edges later, done three edges after the last accept) is compared every cycle on two instances.
module tb_approx_adder_eval_ctrl;
  localparam int W     = 32;
  localparam int N_W   = 16;
  localparam int ACC_W = 2*W+2+N_W;
  localparam int ACC4  = 4;

  typedef longint unsigned u64_t;
  typedef struct { u64_t ae; longint due; } pend_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic start = 1'b0;
  logic [N_W-1:0] num_samples = '0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic in_ready, busy, done, ovf;
  logic [W-1:0] dut_a, dut_b;
  logic [W:0] dut_sum, max_ae;
  logic [N_W-1:0] n_done, err_cnt;
  logic [ACC_W-1:0] sae, sse;

  logic in_ready4, busy4, done4, ovf4;
  logic [W-1:0] dut_a4, dut_b4;
  logic [W:0] dut_sum4, max_ae4;
  logic [N_W-1:0] n_done4, err_cnt4;
  logic [ACC4-1:0] sae4, sse4;

  int mode = 0;
  longint cerr = 0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  // Adder under test: exact sum plus an operand-dependent error, kept inside 33 bits.
  function automatic longint adder_err(logic [W-1:0] a, logic [W-1:0] b, int m, longint c);
    longint ex, e;
    logic [31:0] h;
    ex = longint'(a) + longint'(b);
    case (m)
      0: e = c;
      1: e = (a == 32'd1) ? 64'sd5 : (a == 32'd2) ? -64'sd2 : 64'sd0;
      default: begin
        h = (a * 32'd2654435761) ^ b;
        if (h[7]) e = longint'(h[27:8]);
        else      e = longint'(h[2:0]);
        if (h[31]) e = -e;
      end
    endcase
    if (e < 0 && ex < -e) e = 0;
    if (e > 0 && ex + e > 64'sh1_FFFF_FFFF) e = 0;
    return e;
  endfunction

  function automatic u64_t absl(longint v);
    return (v < 0) ? u64_t'(-v) : u64_t'(v);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      default: return W'($urandom);
    endcase
  endfunction

  assign dut_sum  = 33'(longint'(dut_a)  + longint'(dut_b)  + adder_err(dut_a,  dut_b,  mode, cerr));
  assign dut_sum4 = 33'(longint'(dut_a4) + longint'(dut_b4) + adder_err(dut_a4, dut_b4, mode, cerr));

  approx_adder_eval_ctrl #(.W(W), .N_W(N_W), .ACC_W(ACC_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum), .busy(busy), .done(done),
    .n_done(n_done), .max_ae(max_ae), .sae(sae), .sse(sse), .err_cnt(err_cnt), .ovf(ovf)
  );

  approx_adder_eval_ctrl #(.W(W), .N_W(N_W), .ACC_W(ACC4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
    .dut_a(dut_a4), .dut_b(dut_b4), .dut_sum(dut_sum4), .busy(busy4), .done(done4),
    .n_done(n_done4), .max_ae(max_ae4), .sae(sae4), .sse(sse4), .err_cnt(err_cnt4), .ovf(ovf4)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model
  pend_t  pq[$];
  longint edge_n = 0;
  longint m_target, m_issued, m_done_at;
  bit     m_busy, m_done, m_ready, m_acc;
  u64_t   m_n, m_max, m_sae, m_sse, m_err;
  logic [W-1:0] m_a, m_b;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pq.delete();
      m_target = 0; m_issued = 0; m_done_at = -1;
      m_busy = 0; m_done = 0; m_ready = 0; m_acc = 0;
      m_n = 0; m_max = 0; m_sae = 0; m_sse = 0; m_err = 0;
      m_a = '0; m_b = '0;
    end else begin
      edge_n++;
      m_acc = 0;
      while (pq.size() > 0 && pq[0].due == edge_n) begin
        pend_t p;
        p = pq.pop_front();
        m_n++;
        m_sae += p.ae;
        m_sse += p.ae * p.ae;
        if (p.ae != 0) m_err++;
        if (p.ae > m_max) m_max = p.ae;
      end
      if (m_busy) begin
        if (m_ready && in_valid) begin
          m_acc = 1;
          m_a = in_a;
          m_b = in_b;
          pq.push_back('{ae: absl(adder_err(in_a, in_b, mode, cerr)), due: edge_n + 2});
          m_issued++;
          if (m_issued == m_target) m_done_at = edge_n + 3;
        end
        if (m_done_at == edge_n) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (start) begin
        m_n = 0; m_max = 0; m_sae = 0; m_sse = 0; m_err = 0;
        m_target = longint'(num_samples);
        m_issued = 0;
        m_done_at = -1;
        m_busy = (num_samples != '0);
        m_done = (num_samples == '0);
      end
      m_ready = m_busy && (m_issued < m_target);
    end
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("in_ready", in_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("dut_a", dut_a, m_a);
      chk("dut_b", dut_b, m_b);
      chk("n_done", n_done, m_n);
      chk("max_ae", max_ae, m_max);
      chk("sae", sae, m_sae);
      chk("sse", sse, m_sse);
      chk("err_cnt", err_cnt, m_err);
      chk("ovf", ovf, 1'b0);
      chk("in_ready4", in_ready4, m_ready);
      chk("busy4", busy4, m_busy);
      chk("done4", done4, m_done);
      chk("dut_a4", dut_a4, m_a);
      chk("dut_b4", dut_b4, m_b);
      chk("n_done4", n_done4, m_n);
      chk("max_ae4", max_ae4, m_max);
      chk("err_cnt4", err_cnt4, m_err);
      chk("sae4", sae4, (m_sae > 15) ? u64_t'(15) : m_sae);
      chk("sse4", sse4, (m_sse > 15) ? u64_t'(15) : m_sse);
      chk("ovf4", ovf4, (m_sae > 15) || (m_sse > 15));
    end
  end

  // Stimulus helpers: inputs change 2 time units after each rising edge.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic begin_run(input int n);
    start = 1'b1;
    num_samples = N_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int budget);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while (idx < qa.size() && cyc < budget) begin
      in_valid = 1'b1;
      in_a = qa[idx];
      in_b = qb[idx];
      tick();
      cyc++;
      if (m_acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < qa.size()) chk("feed_timeout", 128'(idx), 128'(qa.size()));
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  task automatic set_pairs3(input logic [W-1:0] a0, b0, a1, b1, a2, b2);
    qa.delete(); qb.delete();
    qa.push_back(a0); qb.push_back(b0);
    qa.push_back(a1); qb.push_back(b1);
    qa.push_back(a2); qb.push_back(b2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_dut_a"}, dut_a, 0);
    chk({tag, "_dut_b"}, dut_b, 0);
    chk({tag, "_n_done"}, n_done, 0);
    chk({tag, "_max_ae"}, max_ae, 0);
    chk({tag, "_sae"}, sae, 0);
    chk({tag, "_sse"}, sse, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_ovf4"}, ovf4, 1'b0);
    chk({tag, "_sse4"}, sse4, 0);
  endtask

  logic [5:0] pat;
  logic [5:0] xfer;
  longint     s_edge;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk_all_zero("reset");
    Rst_n = 1'b1;
    tick();

    // 1: loopback, 4 samples, continuous valid
    mode = 0; cerr = 0;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(rnd_op());
      qb.push_back(rnd_op());
    end
    begin_run(4);
    s_edge = edge_n;
    feed(20);
    wait_done(20);
    chk("t1_latency", 128'(edge_n - s_edge), 128'(7));
    chk("t1_n_done", n_done, 4);
    chk("t1_sae", sae, 0);
    chk("t1_err_cnt", err_cnt, 0);

    // 2: constant +3 error
    mode = 0; cerr = 3;
    set_pairs3(32'd10, 32'd20, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1);
    begin_run(3);
    feed(20);
    wait_done(20);
    chk("t2_sae", sae, 9);
    chk("t2_sse", sse, 27);
    chk("t2_max_ae", max_ae, 3);
    chk("t2_err_cnt", err_cnt, 3);
    chk("t2_n_done", n_done, 3);
    chk("t2_model_sse", 128'(m_sse), 128'(27));

    // 3: errors +5, -2, 0
    mode = 1;
    set_pairs3(32'd1, 32'd100, 32'd2, 32'd100, 32'd3, 32'd100);
    begin_run(3);
    feed(20);
    wait_done(20);
    chk("t3_sae", sae, 7);
    chk("t3_sse", sse, 29);
    chk("t3_max_ae", max_ae, 5);
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_model_sae", 128'(m_sae), 128'(7));

    // 4: sparse valids, start pulsed during DRAIN
    mode = 0; cerr = 0;
    pat = 6'b111001;
    xfer = '0;
    begin_run(2);
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_a = rnd_op();
      in_b = rnd_op();
      start = (i == 4);
      num_samples = N_W'(9);
      xfer[i] = in_valid & in_ready;
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_done(20);
    repeat (3) tick();
    chk("t4_xfer", xfer, 6'b001001);
    chk("t4_n_done", n_done, 2);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b1);

    // 5: zero-length run, then one sample with error 7
    begin_run(0);
    chk("t5_done", done, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_n_done", n_done, 0);
    mode = 0; cerr = 7;
    qa.delete(); qb.delete();
    qa.push_back(32'd1234); qb.push_back(32'd4321);
    begin_run(1);
    feed(20);
    wait_done(20);
    chk("t5_sae", sae, 7);
    chk("t5_n_done1", n_done, 1);

    // 6: async reset mid-run, then saturation on the narrow instance
    mode = 0; cerr = 3;
    begin_run(5);
    for (int c = 0; c < 20 && m_issued < 2; c++) begin
      in_valid = 1'b1;
      in_a = rnd_op();
      in_b = rnd_op();
      tick();
    end
    chk("t6_two_accepts", 128'(m_issued), 128'(2));
    #1 Rst_n = 1'b0;
    in_valid = 1'b0;
    #1 chk_all_zero("t6_reset");
    tick();
    Rst_n = 1'b1;
    tick();
    qa.delete(); qb.delete();
    qa.push_back(32'd7); qb.push_back(32'd8);
    qa.push_back(32'd9); qb.push_back(32'd10);
    begin_run(2);
    feed(20);
    wait_done(20);
    chk("t6_sse4", sse4, 15);
    chk("t6_ovf4", ovf4, 1'b1);
    chk("t6_sae4", sae4, 6);
    chk("t6_sse", sse, 18);
    chk("t6_ovf", ovf, 1'b0);

    // Randomized runs with hashed errors and stray start pulses
    mode = 2;
    for (int r = 0; r < 8; r++) begin
      int n, thr, c;
      n = $urandom_range(1, 20);
      thr = $urandom_range(30, 100);
      begin_run(n);
      c = 0;
      while (!done && c < 300) begin
        in_valid = ($urandom_range(0, 99) < thr);
        in_a = rnd_op();
        in_b = rnd_op();
        start = ($urandom_range(0, 19) == 0);
        num_samples = N_W'($urandom_range(0, 30));
        tick();
        c++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      chk("rand_done", done, 1'b1);
      chk("rand_n_done", n_done, n);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
